// File: rtl/ping_responder.sv
`default_nettype none
// ============================================================================
//  Module      : ping_responder
//  Description : Far-end transponder for the phase-ping link. Qualifies a
//                received burst of rx_stb pulses inside a window, answers
//                with a reply burst at a fixed turnaround delay from the
//                first pulse, then ignores the receiver for a holdoff time.
//                Counts answered pings and rejected windows.
//  Revision    : 1.0  initial release
// ============================================================================
module ping_responder #(
  parameter int CW        = 16,
  parameter int WIN       = 256,
  parameter int MIN_HITS  = 4,
  parameter int TURN_DLY  = 1024,
  parameter int BURST_LEN = 512,
  parameter int HOLDOFF   = 2048
) (
  input  logic          clk,
  input  logic          rst,        // asynchronous, active-low
  input  logic          enable,
  input  logic          rx_stb,
  output logic          reply_stb,
  output logic          reply_en,
  output logic          busy,
  output logic [CW-1:0] ping_cnt,
  output logic [CW-1:0] miss_cnt
);

  // State encoding
  localparam logic [2:0] c_IDLE    = 3'd0;
  localparam logic [2:0] c_WINDOW  = 3'd1;
  localparam logic [2:0] c_TURN    = 3'd2;
  localparam logic [2:0] c_REPLY   = 3'd3;
  localparam logic [2:0] c_HOLDOFF = 3'd4;

  // Timer values at which each phase ends. The timer holds k during the
  // cycle leading up to clock edge T0+k, so comparing against k acts on
  // that edge.
  localparam logic [CW-1:0] c_ONE       = CW'(1);
  localparam logic [CW-1:0] c_WIN       = CW'(WIN);
  localparam logic [CW-1:0] c_MIN_HITS  = CW'(MIN_HITS);
  localparam logic [CW-1:0] c_TURN_END  = CW'(TURN_DLY);
  localparam logic [CW-1:0] c_REPLY_END = CW'(TURN_DLY + BURST_LEN);
  localparam logic [CW-1:0] c_HOLD_END  = CW'(TURN_DLY + BURST_LEN + HOLDOFF);
  localparam logic [CW-1:0] c_HITS_MAX  = '1;
  localparam longint        c_LIMIT     = longint'(1) << CW;

  // Reject parameter sets that cannot work with this timer width or ordering
  if (TURN_DLY <= WIN) begin : g_chk_turn
    $error("ping_responder: TURN_DLY must be greater than WIN");
  end
  if (longint'(WIN) >= c_LIMIT || longint'(MIN_HITS) >= c_LIMIT ||
      longint'(TURN_DLY) >= c_LIMIT || longint'(BURST_LEN) >= c_LIMIT ||
      longint'(HOLDOFF) >= c_LIMIT) begin : g_chk_range
    $error("ping_responder: a parameter does not fit in CW bits");
  end

  logic [2:0]    r_state;
  logic [CW-1:0] r_timer;
  logic [CW-1:0] r_hits;
  logic          r_reply_stb;
  logic          r_reply_en;
  logic          r_busy;
  logic [CW-1:0] r_ping_cnt;
  logic [CW-1:0] r_miss_cnt;

  // Responder sequencer: window qualification, turnaround, burst and holdoff
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= c_IDLE;
      r_timer     <= '0;
      r_hits      <= '0;
      r_reply_stb <= 1'b0;
      r_reply_en  <= 1'b0;
      r_busy      <= 1'b0;
      r_ping_cnt  <= '0;
      r_miss_cnt  <= '0;
    end else begin
      r_reply_stb <= 1'b0;
      if (!enable) begin
        // Disarming aborts whatever is in progress without touching counters
        r_state    <= c_IDLE;
        r_timer    <= '0;
        r_hits     <= '0;
        r_reply_en <= 1'b0;
        r_busy     <= 1'b0;
      end else begin
        case (r_state)
          c_IDLE: begin
            if (rx_stb) begin
              r_state <= c_WINDOW;
              r_timer <= c_ONE;
              r_hits  <= c_ONE;
              r_busy  <= 1'b1;
            end
          end
          c_WINDOW: begin
            r_timer <= r_timer + c_ONE;
            if (r_timer == c_WIN) begin
              // Decision edge: a strobe arriving now is deliberately not counted
              if (r_hits >= c_MIN_HITS) begin
                r_state <= c_TURN;
              end else begin
                r_state    <= c_IDLE;
                r_timer    <= '0;
                r_hits     <= '0;
                r_busy     <= 1'b0;
                r_miss_cnt <= r_miss_cnt + c_ONE;
              end
            end else if (rx_stb && (r_hits != c_HITS_MAX)) begin
              r_hits <= r_hits + c_ONE;
            end
          end
          c_TURN: begin
            r_timer <= r_timer + c_ONE;
            if (r_timer == c_TURN_END) begin
              r_state     <= c_REPLY;
              r_reply_stb <= 1'b1;
              r_reply_en  <= 1'b1;
              r_ping_cnt  <= r_ping_cnt + c_ONE;
            end
          end
          c_REPLY: begin
            r_timer <= r_timer + c_ONE;
            if (r_timer == c_REPLY_END) begin
              r_state    <= c_HOLDOFF;
              r_reply_en <= 1'b0;
            end
          end
          c_HOLDOFF: begin
            r_timer <= r_timer + c_ONE;
            if (r_timer == c_HOLD_END) begin
              r_state <= c_IDLE;
              r_timer <= '0;
              r_hits  <= '0;
              r_busy  <= 1'b0;
            end
          end
          default: begin
            r_state    <= c_IDLE;
            r_timer    <= '0;
            r_hits     <= '0;
            r_reply_en <= 1'b0;
            r_busy     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign reply_stb = r_reply_stb;
  assign reply_en  = r_reply_en;
  assign busy      = r_busy;
  assign ping_cnt  = r_ping_cnt;
  assign miss_cnt  = r_miss_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ping_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ping_responder
//  Description : Directed self-checking bench for ping_responder using
//                WIN=8 MIN_HITS=3 TURN_DLY=20 BURST_LEN=5 HOLDOFF=10.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ping_responder;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          enable = 1'b0;
  logic          rx_stb = 1'b0;
  logic          reply_stb;
  logic          reply_en;
  logic          busy;
  logic [CW-1:0] ping_cnt;
  logic [CW-1:0] miss_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  int e_ping   = 0;
  int e_miss   = 0;

  ping_responder #(
    .CW(CW), .WIN(8), .MIN_HITS(3), .TURN_DLY(20), .BURST_LEN(5), .HOLDOFF(10)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .rx_stb(rx_stb),
    .reply_stb(reply_stb), .reply_en(reply_en), .busy(busy),
    .ping_cnt(ping_cnt), .miss_cnt(miss_cnt)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; enable = 1'b0; rx_stb = 1'b0;
    repeat (2) cyc();
    n_checks++; if (reply_stb !== 1'b0) $display("FAIL reset_stb: got %b expected 0", reply_stb); else n_pass++;
    n_checks++; if (reply_en !== 1'b0) $display("FAIL reset_en: got %b expected 0", reply_en); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
    n_checks++; if (ping_cnt !== '0) $display("FAIL reset_ping: got %0d expected 0", ping_cnt); else n_pass++;
    n_checks++; if (miss_cnt !== '0) $display("FAIL reset_miss: got %0d expected 0", miss_cnt); else n_pass++;
    @(negedge clk); rst = 1'b1; enable = 1'b1;
    cyc();
  endtask

  // Strobes at T0, T0+2, T0+5: reply at T0+20, burst to T0+24, idle at T0+35
  task automatic test_basic();
    logic [63:0] m;
    m = '0; m[0] = 1'b1; m[2] = 1'b1; m[5] = 1'b1;
    for (int k = 0; k <= 36; k++) begin
      rx_stb = m[k];
      cyc();
      n_checks++; if (reply_stb !== (k == 20)) $display("FAIL basic_stb k=%0d: got %b expected %b", k, reply_stb, (k == 20)); else n_pass++;
      n_checks++; if (reply_en !== (k >= 20 && k <= 24)) $display("FAIL basic_en k=%0d: got %b expected %b", k, reply_en, (k >= 20 && k <= 24)); else n_pass++;
      n_checks++; if (busy !== (k < 35)) $display("FAIL basic_busy k=%0d: got %b expected %b", k, busy, (k < 35)); else n_pass++;
    end
    rx_stb = 1'b0;
    e_ping++;
    n_checks++; if (ping_cnt !== CW'(e_ping)) $display("FAIL basic_ping: got %0d expected %0d", ping_cnt, e_ping); else n_pass++;
    n_checks++; if (miss_cnt !== CW'(e_miss)) $display("FAIL basic_miss: got %0d expected %0d", miss_cnt, e_miss); else n_pass++;
  endtask

  // Strobes at T0, T0+3: rejected at T0+8; a strobe at T0+9 opens a new window
  task automatic test_miss();
    logic [63:0] m;
    m = '0; m[0] = 1'b1; m[3] = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      rx_stb = m[k];
      cyc();
      n_checks++; if (busy !== (k < 8)) $display("FAIL miss_busy k=%0d: got %b expected %b", k, busy, (k < 8)); else n_pass++;
    end
    e_miss++;
    n_checks++; if (miss_cnt !== CW'(e_miss)) $display("FAIL miss_cnt: got %0d expected %0d", miss_cnt, e_miss); else n_pass++;
    rx_stb = 1'b1;
    cyc();
    n_checks++; if (busy !== 1'b1) $display("FAIL miss_reopen: got %b expected 1", busy); else n_pass++;
    // Let the single-hit window expire
    rx_stb = 1'b0;
    repeat (8) cyc();
    e_miss++;
    n_checks++; if (busy !== 1'b0) $display("FAIL miss_expire_busy: got %b expected 0", busy); else n_pass++;
    n_checks++; if (miss_cnt !== CW'(e_miss)) $display("FAIL miss_expire_cnt: got %0d expected %0d", miss_cnt, e_miss); else n_pass++;
    n_checks++; if (ping_cnt !== CW'(e_ping)) $display("FAIL miss_ping: got %0d expected %0d", ping_cnt, e_ping); else n_pass++;
  endtask

  // Strobe on the decision edge is not counted: T0, T0+1, T0+8 -> 2 hits
  task automatic test_decision_edge();
    logic [63:0] m;
    m = '0; m[0] = 1'b1; m[1] = 1'b1; m[8] = 1'b1;
    for (int k = 0; k <= 9; k++) begin
      rx_stb = m[k];
      cyc();
      n_checks++; if (busy !== (k < 8)) $display("FAIL dec_busy k=%0d: got %b expected %b", k, busy, (k < 8)); else n_pass++;
    end
    rx_stb = 1'b0;
    e_miss++;
    n_checks++; if (miss_cnt !== CW'(e_miss)) $display("FAIL dec_miss: got %0d expected %0d", miss_cnt, e_miss); else n_pass++;
    repeat (25) cyc();
    n_checks++; if (ping_cnt !== CW'(e_ping)) $display("FAIL dec_ping: got %0d expected %0d", ping_cnt, e_ping); else n_pass++;
  endtask

  // Extra strobes in TURN, REPLY and HOLDOFF must not start anything
  task automatic test_ignore();
    logic [63:0] m;
    m = '0;
    m[0] = 1'b1; m[1] = 1'b1; m[2] = 1'b1;
    m[10] = 1'b1; m[15] = 1'b1; m[22] = 1'b1; m[30] = 1'b1; m[34] = 1'b1;
    for (int k = 0; k <= 35; k++) begin
      rx_stb = m[k];
      cyc();
      n_checks++; if (reply_stb !== (k == 20)) $display("FAIL ign_stb k=%0d: got %b expected %b", k, reply_stb, (k == 20)); else n_pass++;
      n_checks++; if (busy !== (k < 35)) $display("FAIL ign_busy k=%0d: got %b expected %b", k, busy, (k < 35)); else n_pass++;
    end
    e_ping++;
    n_checks++; if (ping_cnt !== CW'(e_ping)) $display("FAIL ign_ping: got %0d expected %0d", ping_cnt, e_ping); else n_pass++;
    // First cycle back in IDLE: a strobe opens a window
    rx_stb = 1'b1;
    cyc();
    n_checks++; if (busy !== 1'b1) $display("FAIL ign_reopen: got %b expected 1", busy); else n_pass++;
    // Aborting that window by disarming counts no miss
    rx_stb = 1'b0; enable = 1'b0;
    cyc();
    n_checks++; if (busy !== 1'b0) $display("FAIL ign_abort_busy: got %b expected 0", busy); else n_pass++;
    n_checks++; if (miss_cnt !== CW'(e_miss)) $display("FAIL ign_abort_miss: got %0d expected %0d", miss_cnt, e_miss); else n_pass++;
    enable = 1'b1;
    cyc();
  endtask

  // enable dropped after edge T0+22: reply_en low from T0+23
  task automatic test_enable_drop();
    logic [63:0] m;
    m = '0; m[0] = 1'b1; m[1] = 1'b1; m[2] = 1'b1;
    for (int k = 0; k <= 22; k++) begin
      rx_stb = m[k];
      cyc();
    end
    rx_stb = 1'b0;
    n_checks++; if (reply_en !== 1'b1) $display("FAIL en_pre: got %b expected 1", reply_en); else n_pass++;
    enable = 1'b0;
    cyc();
    e_ping++;
    n_checks++; if (reply_en !== 1'b0) $display("FAIL en_drop_en: got %b expected 0", reply_en); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL en_drop_busy: got %b expected 0", busy); else n_pass++;
    n_checks++; if (ping_cnt !== CW'(e_ping)) $display("FAIL en_drop_ping: got %0d expected %0d", ping_cnt, e_ping); else n_pass++;
    n_checks++; if (miss_cnt !== CW'(e_miss)) $display("FAIL en_drop_miss: got %0d expected %0d", miss_cnt, e_miss); else n_pass++;
    enable = 1'b1;
    repeat (20) cyc();
    n_checks++; if (reply_en !== 1'b0 || busy !== 1'b0) $display("FAIL en_after: got en=%b busy=%b expected 0/0", reply_en, busy); else n_pass++;
  endtask

  // Async reset mid-burst, then a normal ping from a clean state
  task automatic test_async_reset();
    logic [63:0] m;
    m = '0; m[0] = 1'b1; m[1] = 1'b1; m[2] = 1'b1;
    for (int k = 0; k <= 21; k++) begin
      rx_stb = m[k];
      cyc();
    end
    rx_stb = 1'b0;
    n_checks++; if (reply_en !== 1'b1) $display("FAIL ar_pre: got %b expected 1", reply_en); else n_pass++;
    #2 rst = 1'b0;
    #1;
    n_checks++; if (reply_en !== 1'b0) $display("FAIL ar_en: got %b expected 0", reply_en); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL ar_busy: got %b expected 0", busy); else n_pass++;
    n_checks++; if (ping_cnt !== '0) $display("FAIL ar_ping: got %0d expected 0", ping_cnt); else n_pass++;
    n_checks++; if (miss_cnt !== '0) $display("FAIL ar_miss: got %0d expected 0", miss_cnt); else n_pass++;
    @(negedge clk); rst = 1'b1;
    e_ping = 0; e_miss = 0;
    cyc();
    for (int k = 0; k <= 35; k++) begin
      rx_stb = m[k];
      cyc();
      n_checks++; if (reply_stb !== (k == 20)) $display("FAIL ar_stb k=%0d: got %b expected %b", k, reply_stb, (k == 20)); else n_pass++;
    end
    rx_stb = 1'b0;
    e_ping++;
    n_checks++; if (ping_cnt !== CW'(e_ping)) $display("FAIL ar_ping_after: got %0d expected %0d", ping_cnt, e_ping); else n_pass++;
  endtask

  // Test sequence
  initial begin
    test_reset();
    test_basic();
    test_miss();
    test_decision_edge();
    test_ignore();
    test_enable_drop();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
